aes32dsi_round_seq: RTL and testbench

- Sequential AES inverse-round engine that runs the RV32 scalar decrypt sequence `aes32dsi` / `aes32dsmi` over a full 128-bit state, byte-step by byte-step.
- It is the decrypt counterpart of the `aes32esi` execute unit: inverse S-box instead of S-box, and InvMixColumn instead of MixColumn.
- It sits beside the scalar crypto execute path and serves as the block-level decrypt-round accelerator and golden sequencer for the step units.

---
 rtl/aes32dsi_round_seq_pkg.sv | 62 ++++++
 rtl/aes32ds_step.sv | 23 ++
 rtl/aes32dsi_round_seq.sv | 101 ++++++++++
 tb/tb_aes32dsi_round_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes32dsi_round_seq_pkg.sv
// Shared AES decrypt helpers: inverse S-box, GF(2^8) multiply, FSM states, index helpers.
// Pure functions and constants, no state; consumed by the step unit and the round sequencer.
package aes_pkg;

  localparam logic [8:0] POLY = 9'h11B;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? POLY[7:0] : 8'h00);
  endfunction

  // Only the low nibble of the coefficient matters: 0x09/0x0B/0x0D/0x0E.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] m2, m4, m8;
    m2 = xtime(b);
    m4 = xtime(m2);
    m8 = xtime(m4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? m2 : 8'h00) ^ (c[2] ? m4 : 8'h00) ^ (c[3] ? m8 : 8'h00);
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] s, input logic [1:0] idx);
    return s[32*idx +: 32];
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] w, input logic [1:0] bs);
    case (bs)
      2'd1:    return {w[23:0], w[31:24]};
      2'd2:    return {w[15:0], w[31:16]};
      2'd3:    return {w[7:0],  w[31:8]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/aes32ds_step.sv
// One aes32dsi/aes32dsmi byte-step: acc_nxt = acc ^ rol(f(InvSbox(src.byte[bs])), 8*bs).
// Combinational, no latency; no flow control.
module aes32ds_step
  import aes_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [31:0] src,
  input  logic [1:0]  bs,
  input  logic        mix,
  output logic [31:0] acc_nxt
);

  logic [7:0]  s;
  logic [31:0] w;

  always_comb begin
    s = inv_sbox(get_byte(src, bs));
    if (mix) w = {gf_mul(s, 4'hB), gf_mul(s, 4'hD), gf_mul(s, 4'h9), gf_mul(s, 4'hE)};
    else     w = {24'h0, s};
    acc_nxt = acc ^ rol32(w, bs);
  end

endmodule

// File: rtl/aes32dsi_round_seq.sv
// Full-state AES inverse round built from LANES chained aes32ds steps per cycle.
// Latency 16/LANES+1 cycles accept-to-valid; one request in flight, result held until out_ready.
module aes32dsi_round_seq
  import aes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] rkey_in,
  input  logic         final_rnd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("aes32dsi_round_seq: LANES must be 1, 2 or 4");
  end

  state_e             st_q, st_nxt;
  logic [3:0][31:0]   acc_q;
  logic [127:0]       state_q;
  logic               mix_q;
  logic [3:0]         step_q;
  logic               accept, run, last_grp;
  logic [1:0]         col;
  logic [31:0]        lane_acc [LANES+1];

  assign col       = step_q[3:2];
  assign last_grp  = (step_q == 4'(16 - LANES));
  assign state_out = acc_q;

  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_nxt;
  end

  always_comb begin
    st_nxt    = st_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    run       = 1'b0;
    case (st_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          st_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        run = 1'b1;
        if (last_grp) st_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Each group stays inside one column; source word (col - bs) mod 4 realises InvShiftRows.
  assign lane_acc[0] = acc_q[col];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [1:0] bs, src_idx;
    assign bs      = step_q[1:0] + 2'(l);
    assign src_idx = col - bs;
    aes32ds_step u_step (
      .acc     (lane_acc[l]),
      .src     (get_word(state_q, src_idx)),
      .bs      (bs),
      .mix     (mix_q),
      .acc_nxt (lane_acc[l+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      state_q <= '0;
      mix_q   <= 1'b0;
      step_q  <= '0;
    end else if (accept) begin
      acc_q   <= rkey_in;
      state_q <= state_in;
      mix_q   <= ~final_rnd;
      step_q  <= '0;
    end else if (run) begin
      acc_q[col] <= lane_acc[LANES];
      step_q     <= step_q + 4'(LANES);
    end
  end

endmodule

// File: tb/tb_aes32dsi_round_seq.sv
// Checks LANES=1/2/4 engines side by side against an independent inverse-round model.
module tb_aes32dsi_round_seq;

  logic         clk = 1'b0;
  logic         rst, in_valid, final_rnd, out_ready;
  logic [127:0] state_in, rkey_in;
  logic         ir1, ir2, ir4, ov1, ov2, ov4;
  logic [127:0] so1, so2, so4;

  always #5 clk = ~clk;

  aes32dsi_round_seq #(.LANES(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .state_in(state_in), .rkey_in(rkey_in), .final_rnd(final_rnd), .out_valid(ov1),
    .out_ready(out_ready), .state_out(so1));
  aes32dsi_round_seq #(.LANES(2)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .state_in(state_in), .rkey_in(rkey_in), .final_rnd(final_rnd), .out_valid(ov2),
    .out_ready(out_ready), .state_out(so2));
  aes32dsi_round_seq #(.LANES(4)) u4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
    .state_in(state_in), .rkey_in(rkey_in), .final_rnd(final_rnd), .out_valid(ov4),
    .out_ready(out_ready), .state_out(so4));

  typedef struct {
    logic [127:0] st;
    logic [127:0] rk;
    logic         fin;
    logic [127:0] exp;
  } vec_t;

  int           n_chk = 0, n_err = 0;
  int           edges = 0, acc_edge, lat1, lat2, lat4;
  logic [7:0]   inv_tab [256];
  logic [127:0] exp_q [$];

  always @(posedge clk) edges++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference arithmetic: shift-and-add multiply, S-box from field inverse + affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, xb;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tab[s] = xb;
    end
  endtask

  function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic fin);
    logic [127:0] res;
    logic [31:0]  acc, src, w;
    logic [7:0]   t;
    int           sw;
    for (int j = 0; j < 4; j++) begin
      acc = rk[32*j +: 32];
      for (int b = 0; b < 4; b++) begin
        sw  = (j - b + 4) % 4;
        src = st[32*sw +: 32];
        t   = inv_tab[src[8*b +: 8]];
        if (fin) w = {24'h0, t};
        else     w = {gmul(t, 8'h0B), gmul(t, 8'h0D), gmul(t, 8'h09), gmul(t, 8'h0E)};
        if (b != 0) w = (w << (8*b)) | (w >> (32 - 8*b));
        acc = acc ^ w;
      end
      res[32*j +: 32] = acc;
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with all engines idle; returns at the negedge after the accept edge.
  task automatic do_accept(input logic [127:0] st, input logic [127:0] rk, input logic fin,
                           input logic [127:0] exp);
    state_in = st; rkey_in = rk; final_rnd = fin; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc_edge = edges;
    exp_q.push_back(exp);
  endtask

  task automatic wait_valid();
    lat1 = 0; lat2 = 0; lat4 = 0;
    for (int i = 0; i < 40; i++) begin
      if (ov1 && lat1 == 0) lat1 = edges - acc_edge + 1;
      if (ov2 && lat2 == 0) lat2 = edges - acc_edge + 1;
      if (ov4 && lat4 == 0) lat4 = edges - acc_edge + 1;
      if (lat1 != 0 && lat2 != 0 && lat4 != 0) break;
      @(negedge clk);
    end
    chk("latency_l1", 128'(lat1), 128'd17);
    chk("latency_l2", 128'(lat2), 128'd9);
    chk("latency_l4", 128'(lat4), 128'd5);
  endtask

  task automatic pop_check(input string tag);
    logic [127:0] e;
    e = exp_q.pop_front();
    chk({tag, "_l1"}, so1, e);
    chk({tag, "_l2"}, so2, e);
    chk({tag, "_l4"}, so4, e);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_hs", {126'h0, ov1 | ov2 | ov4, ir1 & ir2 & ir4}, 128'h1);
  endtask

  initial begin
    vec_t         vecs [$];
    vec_t         v;
    logic [127:0] e_a, st_b, rk_b, st_c;
    logic         seen;

    build_tables();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; final_rnd = 1'b0;
    state_in = '0; rkey_in = '0;

    v.st = '0; v.rk = '0; v.fin = 1'b1; v.exp = {16{8'h52}}; vecs.push_back(v);
    v.st = {16{8'h63}}; v.rk = {16{8'hFF}}; v.fin = 1'b1; v.exp = {16{8'hFF}}; vecs.push_back(v);
    v.st = {16{8'h63}}; v.st[47:40] = 8'h2E; v.rk = '0; v.fin = 1'b1;
    v.exp = 128'h0000_0000_0000_C300_0000_0000_0000_0000; vecs.push_back(v);
    v.st = '0; v.rk = '0; v.fin = 1'b0; v.exp = {16{8'h52}}; vecs.push_back(v);
    for (int i = 0; i < 6; i++) begin
      v.st  = {$urandom, $urandom, $urandom, $urandom};
      v.rk  = {$urandom, $urandom, $urandom, $urandom};
      v.fin = 1'($urandom_range(0, 1));
      v.exp = ref_round(v.st, v.rk, v.fin);
      vecs.push_back(v);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", {125'h0, ir1, ir2, ir4}, 128'h7);
    chk("reset_out_valid", {125'h0, ov1, ov2, ov4}, 128'h0);
    chk("reset_state_out", so1 | so2 | so4, 128'h0);

    foreach (vecs[i]) begin
      do_accept(vecs[i].st, vecs[i].rk, vecs[i].fin, vecs[i].exp);
      wait_valid();
      pop_check($sformatf("vec%0d", i));
      release_out();
    end

    // Backpressure: hold result for 5 cycles while a new request is offered.
    v    = vecs[4];
    st_b = {$urandom, $urandom, $urandom, $urandom};
    rk_b = {$urandom, $urandom, $urandom, $urandom};
    do_accept(v.st, v.rk, v.fin, v.exp);
    wait_valid();
    e_a = exp_q[0];
    pop_check("bp_first");
    state_in = st_b; rkey_in = rk_b; final_rnd = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", {125'h0, ov1, ov2, ov4}, 128'h7);
      chk("bp_state_stable", so1, e_a);
      chk("bp_in_ready", {125'h0, ir1, ir2, ir4}, 128'h0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_after_hs", {126'h0, ov1 | ov2 | ov4, ir1 & ir2 & ir4}, 128'h1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc_edge = edges;
    exp_q.push_back(ref_round(st_b, rk_b, 1'b0));
    chk("bp_next_accepted", {125'h0, ir1, ir2, ir4}, 128'h0);
    wait_valid();
    pop_check("bp_second");
    release_out();

    // Reset while the LANES=1 engine is on step 7.
    st_c = {$urandom, $urandom, $urandom, $urandom};
    do_accept(st_c, vecs[5].rk, 1'b0, ref_round(st_c, vecs[5].rk, 1'b0));
    seen = 1'b0;
    repeat (7) begin
      @(negedge clk);
      seen |= ov1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    chk("rst_mid_in_ready", {125'h0, ir1, ir2, ir4}, 128'h7);
    chk("rst_mid_state_out", so1 | so2 | so4, 128'h0);
    repeat (20) begin
      @(negedge clk);
      seen |= ov1 | ov2 | ov4;
    end
    chk("rst_mid_no_output", {127'h0, seen}, 128'h0);
    do_accept(vecs[6].st, vecs[6].rk, vecs[6].fin, vecs[6].exp);
    wait_valid();
    pop_check("post_rst");
    release_out();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
